mig_write_ctrl: RTL
===================

# mig_write_ctrl

Single-burst write engine between the pixel-buffer write requester and the MIG 7-series user interface (UI), running entirely in the memory clock domain. It accepts one request/acknowledge transaction at a time, pops one 128-bit word from the pixel CDC FIFO, and issues one BL8 write: command plus a single UI data beat carrying `app_wdf_end`. It returns `mem_wr_ack` only after the MIG has accepted both the command and the data.

## Interface
- `ADDR_WIDTH`, 29: UI word address width.
- `DATA_WIDTH`, 128: UI data width; mask width is `DATA_WIDTH/8`.
- `CMD_WRITE`, 3'b000: MIG write opcode.

Ports:
- `clk` in 1: memory UI clock; all logic runs on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `init_calib_complete` in 1: MIG calibration done.
- `mem_wr_req` in 1: write request; held high until acknowledged.
- `mem_wr_addr` in ADDR_WIDTH: burst address, valid while `mem_wr_req` is high.
- `mem_wr_ack` out 1: one-cycle pulse marking transaction complete.
- `mem_wdata_rd_en` out 1: pixel FIFO read strobe.
- `mem_wdf_data` in DATA_WIDTH: pixel FIFO dout, standard read with 1-cycle latency.
- `fifo_empty` in 1: pixel FIFO empty.
- `app_addr` out ADDR_WIDTH, `app_cmd` out 3, `app_en` out 1, `app_rdy` in 1: MIG command channel.
- `app_wdf_data` out DATA_WIDTH, `app_wdf_mask` out DATA_WIDTH/8, `app_wdf_wren` out 1, `app_wdf_end` out 1, `app_wdf_rdy` in 1: MIG write-data channel.
- `busy` out 1: high whenever state is not S_IDLE.
- `wr_count` out 32: count of acknowledged bursts; wraps modulo 2^32.

## Operation
- States: S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_ACK.
- **S_IDLE**
  - Condition: `mem_wr_req` and `init_calib_complete` both high.
  - Action: latch `mem_wr_addr` into `app_addr`; latch `fifo_empty` into the `empty_flag` register; go to S_FETCH.
  - Requests are ignored while calibration is incomplete.
- **S_FETCH** (1 cycle)
  - `mem_wdata_rd_en` is high only if `empty_flag` = 0. Never read an empty FIFO.
  - Go to S_LOAD.
- **S_LOAD** (1 cycle)
  - If `empty_flag` = 0: capture `mem_wdf_data` into `app_wdf_data` and set `app_wdf_mask` = 0.
  - If `empty_flag` = 1 (end-of-frame flush with no data): set `app_wdf_data` = 0 and `app_wdf_mask` = all ones, so the burst writes no bytes.
  - Set `app_en` = `app_wdf_wren` = `app_wdf_end` = 1, `app_cmd` = CMD_WRITE. Go to S_ISSUE.
- **S_ISSUE**
  - Command and data channels are independent.
  - `app_en` drops the cycle after `app_en & app_rdy` is sampled high.
  - `app_wdf_wren`/`app_wdf_end` drop the cycle after `app_wdf_wren & app_wdf_rdy` is sampled high.
  - Either channel may be accepted first, or both in the same cycle.
  - When both have been accepted (two sticky done flags): set `mem_wr_ack` = 1, increment `wr_count`, go to S_ACK.
- **S_ACK** (1 cycle)
  - `mem_wr_ack` is high during this cycle.
  - `mem_wr_req` is still high in this cycle (the requester drops it one cycle after seeing ack), so it is ignored here.
  - Go to S_IDLE.
- `app_addr`, `app_wdf_data` and `app_wdf_mask` stay stable from S_LOAD until their channel is accepted.
- `mem_wr_addr` changes while the controller is not idle are ignored; the address is latched once in S_IDLE.

## Timing
- Reset values: all outputs 0, except `app_cmd` = CMD_WRITE. State = S_IDLE, `wr_count` = 0, done flags clear.
- Reset mid-transaction: everything returns to reset values on the next edge; a word already popped is discarded and no ack is issued.
- Minimum latency, with `app_rdy` = `app_wdf_rdy` = 1 and request first high in cycle 0:
  - `rd_en` in cycle 1
  - `app_en`/`app_wdf_wren` in cycle 3
  - `mem_wr_ack` in cycle 4
  - S_IDLE in cycle 5
- Throughput: at most one burst per 5 cycles; a new request can be accepted in cycle 5.
- `mem_wr_ack` is exactly one cycle wide and occurs exactly once per accepted request.
- `app_wdf_end` always equals `app_wdf_wren`.
- `busy` is registered and aligned with the state register.

## Test plan
- **Single burst:** calib = 1, rdy lines tied high, FIFO holding word 128'hA5..01, request at address 29'h100 → exactly one `rd_en` pulse; `app_addr` = 29'h100, `app_cmd` = 0, data = A5..01, mask = 0; ack in cycle 4; `wr_count` = 1.
- **Back-pressure:** `app_rdy` low for 3 cycles, `app_wdf_rdy` low for 6 cycles → `app_en` held 4 cycles, `app_wdf_wren` held 7 cycles with data stable; single ack one cycle after the last acceptance.
- **Data accepted before command:** `app_wdf_rdy` = 1, `app_rdy` low for 5 cycles → `app_wdf_wren` is high for one cycle only; `app_en` held until accepted; exactly one ack.
- **Flush with empty FIFO:** `fifo_empty` = 1 at request → no `rd_en`; data = 0, mask = 16'hFFFF; ack issued; `wr_count` increments.
- **Calibration gating and back-to-back:** request held with calib = 0 for 10 cycles → no activity and `busy` = 0; raise calib, then 64 requests each re-asserted one cycle after ack, addresses incrementing by 8 → 64 acks, 64 pops, correct addresses, no ack merged or duplicated.
- **Reset mid-op:** drop `reset_n` during S_ISSUE → all outputs 0 asynchronously and no ack; after release, the next request completes normally.

Source files
------------

// File: rtl/mig_write_ctrl_if.sv
// Handshake bundle between the write engine, the pixel FIFO/requester
// and the MIG UI. master = write engine side, slave = environment side.
interface mig_write_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 29,
   parameter int unsigned DATA_WIDTH = 128
);
   logic                      init_calib_complete;
   logic                      mem_wr_req;
   logic [ADDR_WIDTH-1:0]     mem_wr_addr;
   logic                      mem_wr_ack;
   logic                      mem_wdata_rd_en;
   logic [DATA_WIDTH-1:0]     mem_wdf_data;
   logic                      fifo_empty;
   logic [ADDR_WIDTH-1:0]     app_addr;
   logic [2:0]                app_cmd;
   logic                      app_en;
   logic                      app_rdy;
   logic [DATA_WIDTH-1:0]     app_wdf_data;
   logic [DATA_WIDTH/8-1:0]   app_wdf_mask;
   logic                      app_wdf_wren;
   logic                      app_wdf_end;
   logic                      app_wdf_rdy;
   logic                      busy;
   logic [31:0]               wr_count;

   modport master (
      input  init_calib_complete, mem_wr_req, mem_wr_addr,
      input  mem_wdf_data, fifo_empty, app_rdy, app_wdf_rdy,
      output mem_wr_ack, mem_wdata_rd_en, app_addr, app_cmd,
      output app_en, app_wdf_data, app_wdf_mask, app_wdf_wren,
      output app_wdf_end, busy, wr_count
   );

   modport slave (
      output init_calib_complete, mem_wr_req, mem_wr_addr,
      output mem_wdf_data, fifo_empty, app_rdy, app_wdf_rdy,
      input  mem_wr_ack, mem_wdata_rd_en, app_addr, app_cmd,
      input  app_en, app_wdf_data, app_wdf_mask, app_wdf_wren,
      input  app_wdf_end, busy, wr_count
   );
endinterface

// File: rtl/mig_write_ctrl.sv
// Single-burst MIG UI write engine: pops one FIFO word, issues one BL8
// write (cmd + one data beat), acks once both channels are accepted.
// Ports: clk, reset_n (async, active low), bus (mig_write_ctrl_if.master).
module mig_write_ctrl #(
   parameter int unsigned ADDR_WIDTH = 29,
   parameter int unsigned DATA_WIDTH = 128,
   parameter logic [2:0]  CMD_WRITE  = 3'b000
) (
   input  logic             clk,
   input  logic             reset_n,
   mig_write_ctrl_if.master bus
);
   localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_ACK
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [MASK_WIDTH-1:0] mask_q, mask_d;
   logic [31:0]           cnt_q, cnt_d;
   logic                  empty_q, empty_d;
   logic                  rd_en_q, rd_en_d;
   logic                  en_q, en_d;
   logic                  wren_q, wren_d;
   logic                  cmd_done_q, cmd_done_d;
   logic                  dat_done_q, dat_done_d;
   logic                  ack_q, ack_d;
   logic                  busy_q, busy_d;
   logic                  cmd_acc, dat_acc;

   assign cmd_acc = en_q & bus.app_rdy;
   assign dat_acc = wren_q & bus.app_wdf_rdy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         cnt_q      <= '0;
         empty_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         en_q       <= 1'b0;
         wren_q     <= 1'b0;
         cmd_done_q <= 1'b0;
         dat_done_q <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         empty_q    <= empty_d;
         rd_en_q    <= rd_en_d;
         en_q       <= en_d;
         wren_q     <= wren_d;
         cmd_done_q <= cmd_done_d;
         dat_done_q <= dat_done_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      cnt_d      = cnt_q;
      empty_d    = empty_q;
      rd_en_d    = 1'b0;
      en_d       = en_q;
      wren_d     = wren_q;
      cmd_done_d = cmd_done_q;
      dat_done_d = dat_done_q;
      ack_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.mem_wr_req && bus.init_calib_complete) begin
               addr_d  = bus.mem_wr_addr;
               empty_d = bus.fifo_empty;
               // rd_en is registered, so it lands in the FETCH cycle
               rd_en_d = ~bus.fifo_empty;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (empty_q) begin
               // flush with no data: fully masked, writes nothing
               data_d = '0;
               mask_d = '1;
            end else begin
               data_d = bus.mem_wdf_data;
               mask_d = '0;
            end
            en_d    = 1'b1;
            wren_d  = 1'b1;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (cmd_acc) en_d = 1'b0;
            if (dat_acc) wren_d = 1'b0;
            cmd_done_d = cmd_done_q | cmd_acc;
            dat_done_d = dat_done_q | dat_acc;
            if (cmd_done_d && dat_done_d) begin
               cmd_done_d = 1'b0;
               dat_done_d = 1'b0;
               ack_d      = 1'b1;
               cnt_d      = cnt_q + 32'd1;
               state_d    = S_ACK;
            end
         end
         S_ACK: begin
            // requester still holds req here; it is not a new request
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign bus.mem_wr_ack      = ack_q;
   assign bus.mem_wdata_rd_en = rd_en_q;
   assign bus.app_addr        = addr_q;
   assign bus.app_cmd         = CMD_WRITE;
   assign bus.app_en          = en_q;
   assign bus.app_wdf_data    = data_q;
   assign bus.app_wdf_mask    = mask_q;
   assign bus.app_wdf_wren    = wren_q;
   assign bus.app_wdf_end     = wren_q;
   assign bus.busy            = busy_q;
   assign bus.wr_count        = cnt_q;
endmodule
